dpb_slot_scheduler: RTL and testbench
=====================================

# dpb_slot_scheduler

Bookkeeping controller for the 16-slot packet ring in the dual-port BRAM that sits between the DDR3 read master and the UDP128 sender. The writer allocates slots and commits them with length/last-fragment metadata. The reader is offered the oldest committed slot, sends it, then releases or retries it. The block owns head/tail pointers, occupancy, full/empty, JPEG frame ranking and IPv4 identification, so the BRAM reader only needs slot numbers and lengths, never in-band header words.

## Interface
- SLOT_W, 4: slot index width; 2**SLOT_W slots.
- MAX_BYTES, 2048: largest payload per slot (128 words × 16 B).
- MAX_RETRY, 3: retries per slot before forced drop.
- i_clk50m  in  1  sole clock; every register is in this domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wr_alloc_req  in  1  writer requests a free slot (level).
- o_wr_alloc_gnt  out  1  one-cycle grant pulse; o_wr_slot valid with it and held until commit.
- o_wr_slot  out  SLOT_W  reserved slot index.
- i_wr_commit  in  1  one-cycle pulse; slot filled.
- i_wr_len  in  16  payload bytes, sampled on commit.
- i_wr_last  in  1  last fragment of a JPEG frame, sampled on commit.
- o_wr_err  out  1  one-cycle pulse on a rejected commit.
- o_full  out  1  no slot allocatable.
- o_rd_valid  out  1  head slot offered.
- o_rd_slot  out  SLOT_W  head slot index.
- o_rd_len  out  16  head payload bytes.
- o_rd_last  out  1  head is a last fragment.
- o_rd_frame_rank  out  15  JPEG frame number of the head.
- o_rd_ipv4_sign  out  16  IPv4 ID for the current send.
- i_rd_start  in  1  reader accepts the offer (pulse, with o_rd_valid).
- i_rd_done  in  1  send finished; release slot (pulse).
- i_rd_retry  in  1  send failed; re-offer same slot (pulse).
- o_rd_drop  out  1  one-cycle pulse when a slot is released after the retry limit.
- o_empty  out  1  no committed slot.
- o_count  out  SLOT_W+1  committed slots.

## Operation
- Writer FSM W_IDLE/W_RESV.
  - W_IDLE with i_wr_alloc_req and not o_full: grant pulse, o_wr_slot = tail, go W_RESV.
  - W_RESV on i_wr_commit:
    - If 1 ≤ i_wr_len ≤ MAX_BYTES: store {last, rank, len} into meta[tail], tail+1, count+1.
    - Otherwise: o_wr_err, nothing stored, tail unchanged.
    - Return to W_IDLE in both cases.
- A reservation counts toward fullness: o_full = (count + (state==W_RESV)) == 2**SLOT_W.
- Frame rank counter: stored with each commit; increments after a valid commit with last=1; wraps mod 2**15.
- Reader FSM R_IDLE/R_OFFER/R_SEND.
  - R_IDLE with count ≠ 0: go R_OFFER. o_rd_valid = (state==R_OFFER); head metadata presented from meta[head].
  - R_OFFER on i_rd_start: ipv4_sign += 2 (wraps mod 2**16), go R_SEND.
  - R_SEND on i_rd_done: head+1, count−1, retry counter = 0, go R_IDLE.
  - R_SEND on i_rd_retry with retry < MAX_RETRY: retry+1, go R_OFFER (same slot).
  - R_SEND on i_rd_retry at the limit: release as for done, pulse o_rd_drop.
- i_rd_done and i_rd_retry together: done wins. Pulses outside their states are ignored.
- Commit and release in the same cycle: count unchanged, both pointers move.
- Pointers wrap naturally mod 2**SLOT_W.
- Reset mid-operation discards all slots and reservations; the writer must re-request.

## Timing
- Reset values:
  - All outputs 0 except o_empty=1.
  - Pointers, counters, rank, ipv4_sign 0.
  - FSMs in W_IDLE/R_IDLE.
- All outputs are registered.
- Alloc latency: grant the cycle after i_wr_alloc_req is first sampled high in W_IDLE. A new grant requires a fresh W_IDLE cycle; at most one reservation is outstanding.
- Commit → o_rd_valid: 2 cycles when empty (count registered, then R_OFFER).
- Release → next o_rd_valid: 2 cycles.
- Retry → re-offer: 1 cycle.
- o_rd_ipv4_sign updates the cycle after i_rd_start and is stable through R_SEND.

## Structure
- Package dpb_slot_pkg:
  - SLOT_W, MAX_BYTES, MAX_RETRY defaults.
  - typedef slot_meta_t {last, rank[14:0], len[15:0]}.
  - enums wr_state_t and rd_state_t.
- Sub-module dpb_slot_meta_ram: 2**SLOT_W × slot_meta_t register file, one write port and one asynchronous read port at head; reset not required.

## Test plan
- Reset, then commit len=1000,last=0 to slot 0 → o_rd_valid 2 cycles later, slot 0, len 1000, rank 0; start → ipv4_sign 2; done → o_empty=1.
- 16 alloc/commit with no reads → o_count=16, o_full=1; further alloc_req gets no grant. One release → grant on slot 0 (wrap).
- Commits with last=1 on fragments 3 and 5 → ranks 0,0,0,1,1,2.
- Retry ×3 then retry again → slot re-offered 3 times, 4th gives o_rd_drop, head advances, ipv4_sign advanced by 8.
- Commit len=0 and len=2049 → o_wr_err each, o_count unchanged, next alloc returns same slot.
- Commit and done in the same cycle with count=5 → count stays 5, both pointers +1. Reset asserted mid-R_SEND → all outputs at reset values.

Source files
------------

// File: rtl/dpb_slot_pkg.sv
// rtl/dpb_slot_pkg.sv - shared types and defaults for the DPB packet-ring slot scheduler
package dpb_slot_pkg;

  localparam int DEF_SLOT_W    = 4;
  localparam int DEF_MAX_BYTES = 2048;
  localparam int DEF_MAX_RETRY = 3;

  // Per-slot bookkeeping kept alongside the BRAM payload.
  typedef struct packed {
    logic        last;
    logic [14:0] rank;
    logic [15:0] len;
  } slot_meta_t;

  typedef enum logic {
    W_IDLE,
    W_RESV
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_OFFER,
    R_SEND
  } rd_state_t;

endpackage

// File: rtl/dpb_slot_meta_ram.sv
// rtl/dpb_slot_meta_ram.sv - per-slot metadata register file, one write port, async read
// Ports:
//   i_clk    clock
//   i_we     write enable, i_waddr/i_wdata written on the rising edge
//   i_raddr  read address (head slot); o_rdata follows combinationally
module dpb_slot_meta_ram
  import dpb_slot_pkg::*;
#(
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [SLOT_W-1:0] i_waddr,
  input  slot_meta_t        i_wdata,
  input  logic [SLOT_W-1:0] i_raddr,
  output slot_meta_t        o_rdata
);

  slot_meta_t mem_q [2**SLOT_W];

  // No reset: a slot is only read after it has been committed.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/dpb_slot_scheduler.sv
// rtl/dpb_slot_scheduler.sv - head/tail/occupancy bookkeeping for the 16-slot DPB packet ring
// Ports:
//   writer : i_wr_alloc_req -> o_wr_alloc_gnt/o_wr_slot, i_wr_commit with i_wr_len/i_wr_last, o_wr_err
//   reader : o_rd_valid with o_rd_slot/len/last/frame_rank/ipv4_sign, i_rd_start, i_rd_done,
//            i_rd_retry, o_rd_drop
//   status : o_full, o_empty, o_count
module dpb_slot_scheduler
  import dpb_slot_pkg::*;
#(
  parameter int SLOT_W    = DEF_SLOT_W,
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic              i_clk50m,
  input  logic              i_rst_n,
  input  logic              i_wr_alloc_req,
  output logic              o_wr_alloc_gnt,
  output logic [SLOT_W-1:0] o_wr_slot,
  input  logic              i_wr_commit,
  input  logic [15:0]       i_wr_len,
  input  logic              i_wr_last,
  output logic              o_wr_err,
  output logic              o_full,
  output logic              o_rd_valid,
  output logic [SLOT_W-1:0] o_rd_slot,
  output logic [15:0]       o_rd_len,
  output logic              o_rd_last,
  output logic [14:0]       o_rd_frame_rank,
  output logic [15:0]       o_rd_ipv4_sign,
  input  logic              i_rd_start,
  input  logic              i_rd_done,
  input  logic              i_rd_retry,
  output logic              o_rd_drop,
  output logic              o_empty,
  output logic [SLOT_W:0]   o_count
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [SLOT_W+1:0] FULL_CNT = (SLOT_W+2)'(2**SLOT_W);

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic [SLOT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [SLOT_W:0]   count_q, count_d;
  logic [14:0]       rank_q, rank_d;
  logic [15:0]       ipv4_q, ipv4_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              gnt_q, gnt_d, err_q, err_d, drop_q, drop_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              commit_ok, release_slot, len_ok;
  slot_meta_t        wr_meta, head_meta;

  assign len_ok  = (i_wr_len != 16'd0) && ({16'd0, i_wr_len} <= MAX_BYTES);
  assign wr_meta = '{last: i_wr_last, rank: rank_q, len: i_wr_len};

  always_comb begin
    wr_state_d   = wr_state_q;
    rd_state_d   = rd_state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    rank_d       = rank_q;
    ipv4_d       = ipv4_q;
    retry_d      = retry_q;
    gnt_d        = 1'b0;
    err_d        = 1'b0;
    drop_d       = 1'b0;
    commit_ok    = 1'b0;
    release_slot = 1'b0;

    unique case (wr_state_q)
      W_IDLE: begin
        if (i_wr_alloc_req && !full_q) begin
          gnt_d      = 1'b1;
          wr_state_d = W_RESV;
        end
      end
      W_RESV: begin
        if (i_wr_commit) begin
          wr_state_d = W_IDLE;
          if (len_ok) commit_ok = 1'b1;
          else        err_d     = 1'b1;
        end
      end
    endcase

    unique case (rd_state_q)
      R_IDLE: begin
        if (count_q != '0) rd_state_d = R_OFFER;
      end
      R_OFFER: begin
        if (i_rd_start) begin
          ipv4_d     = ipv4_q + 16'd2;
          rd_state_d = R_SEND;
        end
      end
      R_SEND: begin
        // done takes priority over a simultaneous retry
        if (i_rd_done) begin
          release_slot = 1'b1;
        end else if (i_rd_retry) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d    = retry_q + RW'(1);
            rd_state_d = R_OFFER;
          end else begin
            release_slot = 1'b1;
            drop_d       = 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    if (commit_ok) begin
      tail_d = tail_q + SLOT_W'(1);
      if (i_wr_last) rank_d = rank_q + 15'd1;
    end

    if (release_slot) begin
      head_d     = head_q + SLOT_W'(1);
      retry_d    = '0;
      rd_state_d = R_IDLE;
    end

    unique case ({commit_ok, release_slot})
      2'b10:   count_d = count_q + (SLOT_W+1)'(1);
      2'b01:   count_d = count_q - (SLOT_W+1)'(1);
      default: count_d = count_q;
    endcase

    // An outstanding reservation occupies a slot for fullness purposes.
    full_d  = ({1'b0, count_d} + ((wr_state_d == W_RESV) ? (SLOT_W+2)'(1) : '0)) == FULL_CNT;
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rank_q     <= '0;
      ipv4_q     <= '0;
      retry_q    <= '0;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rank_q     <= rank_d;
      ipv4_q     <= ipv4_d;
      retry_q    <= retry_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  dpb_slot_meta_ram #(
    .SLOT_W (SLOT_W)
  ) u_meta_ram (
    .i_clk   (i_clk50m),
    .i_we    (commit_ok),
    .i_waddr (tail_q),
    .i_wdata (wr_meta),
    .i_raddr (head_q),
    .o_rdata (head_meta)
  );

  assign o_wr_alloc_gnt  = gnt_q;
  assign o_wr_slot       = tail_q;
  assign o_wr_err        = err_q;
  assign o_full          = full_q;
  assign o_rd_valid      = (rd_state_q == R_OFFER);
  assign o_rd_slot       = head_q;
  // Metadata RAM is unreset; mask it while nothing is committed.
  assign o_rd_len        = empty_q ? '0 : head_meta.len;
  assign o_rd_last       = empty_q ? 1'b0 : head_meta.last;
  assign o_rd_frame_rank = empty_q ? '0 : head_meta.rank;
  assign o_rd_ipv4_sign  = ipv4_q;
  assign o_rd_drop       = drop_q;
  assign o_empty         = empty_q;
  assign o_count         = count_q;

endmodule

// File: tb/tb_dpb_slot_scheduler.sv
// tb/tb_dpb_slot_scheduler.sv - directed self-checking bench for dpb_slot_scheduler
module tb_dpb_slot_scheduler;

  logic        i_clk50m = 1'b0;
  logic        i_rst_n  = 1'b0;
  logic        i_wr_alloc_req = 1'b0;
  logic        o_wr_alloc_gnt;
  logic [3:0]  o_wr_slot;
  logic        i_wr_commit = 1'b0;
  logic [15:0] i_wr_len = '0;
  logic        i_wr_last = 1'b0;
  logic        o_wr_err;
  logic        o_full;
  logic        o_rd_valid;
  logic [3:0]  o_rd_slot;
  logic [15:0] o_rd_len;
  logic        o_rd_last;
  logic [14:0] o_rd_frame_rank;
  logic [15:0] o_rd_ipv4_sign;
  logic        i_rd_start = 1'b0;
  logic        i_rd_done = 1'b0;
  logic        i_rd_retry = 1'b0;
  logic        o_rd_drop;
  logic        o_empty;
  logic [4:0]  o_count;

  int checks = 0;
  int errors = 0;

  always #10 i_clk50m = ~i_clk50m;

  dpb_slot_scheduler dut (
    .i_clk50m        (i_clk50m),
    .i_rst_n         (i_rst_n),
    .i_wr_alloc_req  (i_wr_alloc_req),
    .o_wr_alloc_gnt  (o_wr_alloc_gnt),
    .o_wr_slot       (o_wr_slot),
    .i_wr_commit     (i_wr_commit),
    .i_wr_len        (i_wr_len),
    .i_wr_last       (i_wr_last),
    .o_wr_err        (o_wr_err),
    .o_full          (o_full),
    .o_rd_valid      (o_rd_valid),
    .o_rd_slot       (o_rd_slot),
    .o_rd_len        (o_rd_len),
    .o_rd_last       (o_rd_last),
    .o_rd_frame_rank (o_rd_frame_rank),
    .o_rd_ipv4_sign  (o_rd_ipv4_sign),
    .i_rd_start      (i_rd_start),
    .i_rd_done       (i_rd_done),
    .i_rd_retry      (i_rd_retry),
    .o_rd_drop       (o_rd_drop),
    .o_empty         (o_empty),
    .o_count         (o_count)
  );

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_wr_alloc_req = 1'b0; i_wr_commit = 1'b0; i_wr_len = '0; i_wr_last = 1'b0;
    i_rd_start = 1'b0; i_rd_done = 1'b0; i_rd_retry = 1'b0;
    repeat (2) @(negedge i_clk50m);
    i_rst_n = 1'b1;
    @(negedge i_clk50m);
  endtask

  task automatic do_alloc(output bit ok, output logic [3:0] slot);
    ok = 1'b0;
    slot = '0;
    i_wr_alloc_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk50m);
      if (o_wr_alloc_gnt) begin
        ok = 1'b1;
        slot = o_wr_slot;
        break;
      end
    end
    i_wr_alloc_req = 1'b0;
  endtask

  task automatic do_commit(input logic [15:0] len, input logic last);
    i_wr_commit = 1'b1; i_wr_len = len; i_wr_last = last;
    @(negedge i_clk50m);
    i_wr_commit = 1'b0; i_wr_len = '0; i_wr_last = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_rd_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk50m);
    end
  endtask

  task automatic pulse_start();
    i_rd_start = 1'b1; @(negedge i_clk50m); i_rd_start = 1'b0;
  endtask

  task automatic pulse_done();
    i_rd_done = 1'b1; @(negedge i_clk50m); i_rd_done = 1'b0;
  endtask

  task automatic pulse_retry();
    i_rd_retry = 1'b1; @(negedge i_clk50m); i_rd_retry = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk50m);
    checks++;
    if ({o_wr_alloc_gnt, o_wr_slot, o_wr_err, o_full, o_rd_valid, o_rd_slot, o_rd_drop, o_count} !== '0) begin
      errors++;
      $display("FAIL reset_zero_outputs got gnt=%b wslot=%0d err=%b full=%b valid=%b rslot=%0d drop=%b count=%0d want all 0",
               o_wr_alloc_gnt, o_wr_slot, o_wr_err, o_full, o_rd_valid, o_rd_slot, o_rd_drop, o_count);
    end
    checks++;
    if (o_empty !== 1'b1 || o_rd_ipv4_sign !== 16'd0 || o_rd_len !== 16'd0 || o_rd_frame_rank !== 15'd0 || o_rd_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_outputs got empty=%b ipv4=%0d len=%0d rank=%0d last=%b want empty=1 others 0",
               o_empty, o_rd_ipv4_sign, o_rd_len, o_rd_frame_rank, o_rd_last);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk50m);
  endtask

  task automatic test_basic();
    bit ok;
    logic [3:0] s;
    do_reset();
    do_alloc(ok, s);
    checks++;
    if (!ok || s !== 4'd0) begin
      errors++; $display("FAIL basic_alloc got ok=%b slot=%0d want ok=1 slot=0", ok, s);
    end
    do_commit(16'd1000, 1'b0);
    checks++;
    if (o_rd_valid !== 1'b0 || o_count !== 5'd1) begin
      errors++; $display("FAIL basic_commit_cycle1 got valid=%b count=%0d want valid=0 count=1", o_rd_valid, o_count);
    end
    @(negedge i_clk50m);
    checks++;
    if (o_rd_valid !== 1'b1 || o_rd_slot !== 4'd0 || o_rd_len !== 16'd1000 || o_rd_frame_rank !== 15'd0 || o_rd_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_offer got valid=%b slot=%0d len=%0d rank=%0d last=%b want 1/0/1000/0/0",
               o_rd_valid, o_rd_slot, o_rd_len, o_rd_frame_rank, o_rd_last);
    end
    pulse_start();
    checks++;
    if (o_rd_ipv4_sign !== 16'd2 || o_rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ipv4 got ipv4=%0d valid=%b want ipv4=2 valid=0", o_rd_ipv4_sign, o_rd_valid);
    end
    pulse_done();
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      errors++; $display("FAIL basic_release got empty=%b count=%0d want empty=1 count=0", o_empty, o_count);
    end
  endtask

  task automatic test_full_wrap();
    bit ok;
    bit got;
    logic [3:0] s;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_alloc(ok, s);
      checks++;
      if (!ok || s !== 4'(i)) begin
        errors++; $display("FAIL full_alloc_%0d got ok=%b slot=%0d want ok=1 slot=%0d", i, ok, s, i);
      end
      do_commit(16'(100 + i), 1'b0);
    end
    checks++;
    if (o_count !== 5'd16 || o_full !== 1'b1) begin
      errors++; $display("FAIL full_status got count=%0d full=%b want count=16 full=1", o_count, o_full);
    end
    do_alloc(ok, s);
    checks++;
    if (ok) begin
      errors++; $display("FAIL full_no_grant got grant slot=%0d want no grant", s);
    end
    wait_valid(ok);
    checks++;
    if (!ok || o_rd_slot !== 4'd0 || o_rd_len !== 16'd100) begin
      errors++; $display("FAIL full_head got valid=%b slot=%0d len=%0d want 1/0/100", ok, o_rd_slot, o_rd_len);
    end
    i_wr_alloc_req = 1'b1;
    pulse_start();
    pulse_done();
    got = 1'b0;
    s = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk50m);
      if (o_wr_alloc_gnt) begin
        got = 1'b1;
        s = o_wr_slot;
        break;
      end
    end
    i_wr_alloc_req = 1'b0;
    checks++;
    if (!got || s !== 4'd0) begin
      errors++; $display("FAIL full_wrap_grant got ok=%b slot=%0d want ok=1 slot=0", got, s);
    end
  endtask

  task automatic test_rank();
    bit ok;
    logic [3:0] s;
    logic       lasts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [14:0] ranks [6] = '{15'd0, 15'd0, 15'd0, 15'd1, 15'd1, 15'd2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_alloc(ok, s);
      do_commit(16'(200 + i), lasts[i]);
    end
    for (int i = 0; i < 6; i++) begin
      wait_valid(ok);
      checks++;
      if (!ok || o_rd_slot !== 4'(i) || o_rd_frame_rank !== ranks[i] || o_rd_last !== lasts[i] || o_rd_len !== 16'(200 + i)) begin
        errors++;
        $display("FAIL rank_frag_%0d got valid=%b slot=%0d rank=%0d last=%b len=%0d want 1/%0d/%0d/%b/%0d",
                 i, ok, o_rd_slot, o_rd_frame_rank, o_rd_last, o_rd_len, i, ranks[i], lasts[i], 200 + i);
      end
      pulse_start();
      pulse_done();
    end
  endtask

  task automatic test_retry();
    bit ok;
    logic [3:0] s;
    do_reset();
    do_alloc(ok, s); do_commit(16'd500, 1'b0);
    do_alloc(ok, s); do_commit(16'd600, 1'b0);
    wait_valid(ok);
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      pulse_retry();
      checks++;
      if (o_rd_valid !== 1'b1 || o_rd_slot !== 4'd0 || o_rd_drop !== 1'b0) begin
        errors++;
        $display("FAIL retry_reoffer_%0d got valid=%b slot=%0d drop=%b want 1/0/0", k, o_rd_valid, o_rd_slot, o_rd_drop);
      end
    end
    pulse_start();
    pulse_retry();
    checks++;
    if (o_rd_drop !== 1'b1 || o_rd_valid !== 1'b0 || o_rd_ipv4_sign !== 16'd8 || o_count !== 5'd1) begin
      errors++;
      $display("FAIL retry_drop got drop=%b valid=%b ipv4=%0d count=%0d want 1/0/8/1",
               o_rd_drop, o_rd_valid, o_rd_ipv4_sign, o_count);
    end
    @(negedge i_clk50m);
    checks++;
    if (o_rd_drop !== 1'b0) begin
      errors++; $display("FAIL retry_drop_pulse got drop=%b want 0", o_rd_drop);
    end
    wait_valid(ok);
    checks++;
    if (!ok || o_rd_slot !== 4'd1 || o_rd_len !== 16'd600) begin
      errors++; $display("FAIL retry_next_head got valid=%b slot=%0d len=%0d want 1/1/600", ok, o_rd_slot, o_rd_len);
    end
  endtask

  task automatic test_wr_err();
    bit ok;
    logic [3:0] s;
    do_reset();
    do_alloc(ok, s);
    do_commit(16'd0, 1'b0);
    checks++;
    if (o_wr_err !== 1'b1 || o_count !== 5'd0) begin
      errors++; $display("FAIL err_len0 got err=%b count=%0d want err=1 count=0", o_wr_err, o_count);
    end
    do_alloc(ok, s);
    checks++;
    if (!ok || s !== 4'd0) begin
      errors++; $display("FAIL err_realloc1 got ok=%b slot=%0d want ok=1 slot=0", ok, s);
    end
    do_commit(16'd2049, 1'b1);
    checks++;
    if (o_wr_err !== 1'b1 || o_count !== 5'd0) begin
      errors++; $display("FAIL err_len2049 got err=%b count=%0d want err=1 count=0", o_wr_err, o_count);
    end
    do_alloc(ok, s);
    checks++;
    if (!ok || s !== 4'd0) begin
      errors++; $display("FAIL err_realloc2 got ok=%b slot=%0d want ok=1 slot=0", ok, s);
    end
    do_commit(16'd2048, 1'b0);
    checks++;
    if (o_wr_err !== 1'b0 || o_count !== 5'd1) begin
      errors++; $display("FAIL err_len2048 got err=%b count=%0d want err=0 count=1", o_wr_err, o_count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] s;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_alloc(ok, s);
      do_commit(16'(300 + i), 1'b0);
    end
    wait_valid(ok);
    pulse_start();
    do_alloc(ok, s);
    checks++;
    if (!ok || s !== 4'd5) begin
      errors++; $display("FAIL b2b_alloc got ok=%b slot=%0d want ok=1 slot=5", ok, s);
    end
    i_wr_commit = 1'b1; i_wr_len = 16'd777; i_rd_done = 1'b1;
    @(negedge i_clk50m);
    i_wr_commit = 1'b0; i_wr_len = '0; i_rd_done = 1'b0;
    checks++;
    if (o_count !== 5'd5 || o_rd_slot !== 4'd1 || o_wr_slot !== 4'd6) begin
      errors++;
      $display("FAIL b2b_commit_release got count=%0d head=%0d tail=%0d want 5/1/6", o_count, o_rd_slot, o_wr_slot);
    end
    wait_valid(ok);
    pulse_start();
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_rd_valid !== 1'b0 || o_count !== 5'd0 || o_empty !== 1'b1 || o_rd_ipv4_sign !== 16'd0 ||
        o_rd_slot !== 4'd0 || o_wr_slot !== 4'd0 || o_rd_len !== 16'd0 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL midsend_reset got valid=%b count=%0d empty=%b ipv4=%0d rslot=%0d wslot=%0d len=%0d full=%b want reset values",
               o_rd_valid, o_count, o_empty, o_rd_ipv4_sign, o_rd_slot, o_wr_slot, o_rd_len, o_full);
    end
    @(negedge i_clk50m);
    i_rst_n = 1'b1;
    @(negedge i_clk50m);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_rank();
    test_retry();
    test_wr_err();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
